full_control_system: RTL and testbench

FULL_CONTROL_SYSTEM -- requirements
Module: full_control_system

---
 rtl/full_control_pkg.sv | 18 +
 rtl/budget_lut.sv | 11 +
 rtl/full_control_system.sv | 58 +++++
 tb/tb_full_control_system.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/full_control_pkg.sv
// Shared widths, epoch default and the voltage-level to issue-budget table.
package full_control_pkg;

  localparam int VOLT_W            = 8;
  localparam int ISSUE_W           = 5;
  localparam int LEVEL_W           = 3;
  localparam int EPOCH_LEN_DEFAULT = 16;

  typedef logic [VOLT_W-1:0]  volt_t;
  typedef logic [ISSUE_W-1:0] issue_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // The top level saturates at 31 because 32 does not fit in the 5-bit count.
  localparam issue_t BUDGET_TABLE [0:7] = '{
    5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28, 5'd31
  };

endpackage

// File: rtl/budget_lut.sv
// Combinational map from supply-voltage level to per-epoch issue budget.
module budget_lut
  import full_control_pkg::*;
(
  input  logic [LEVEL_W-1:0] level,
  output logic [ISSUE_W-1:0] budget
);

  assign budget = BUDGET_TABLE[level];

endmodule

// File: rtl/full_control_system.sv
// Per-epoch issue budget for SM1: reloads from voltage at each epoch boundary, then
// counts down by issued instructions, saturating at 0. Output is a flop, one-cycle latency.
module full_control_system
  import full_control_pkg::*;
#(
  parameter int EPOCH_LEN = EPOCH_LEN_DEFAULT
) (
  input  logic               clk_sm,
  input  logic               rst_n,
  input  logic [VOLT_W-1:0]  SM1_voltage,
  input  logic [ISSUE_W-1:0] SM1_issued_this_cycle,
  output logic [ISSUE_W-1:0] SM1_remaining
);

  localparam int EW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam logic [EW-1:0] LAST = EW'(EPOCH_LEN - 1);

  logic [EW-1:0]      epoch_cnt;
  logic [VOLT_W-1:0]  v_reg;
  logic               boundary;
  logic [LEVEL_W-1:0] level;
  logic [ISSUE_W-1:0] budget;
  logic [ISSUE_W-1:0] base;
  logic [ISSUE_W:0]   diff;
  logic [ISSUE_W-1:0] remaining_next;
  logic               unused_vlow;

  assign boundary = (epoch_cnt == '0);

  // Outside a boundary the looked-up budget is ignored, so steer the LUT from the held sample.
  assign level = boundary ? SM1_voltage[VOLT_W-1 -: LEVEL_W] : v_reg[VOLT_W-1 -: LEVEL_W];
  assign unused_vlow = ^v_reg[VOLT_W-LEVEL_W-1:0];

  budget_lut u_budget_lut (
    .level  (level),
    .budget (budget)
  );

  // One extra bit acts as the borrow; a set MSB means the subtraction went negative.
  assign base           = boundary ? budget : SM1_remaining;
  assign diff           = {1'b0, base} - {1'b0, SM1_issued_this_cycle};
  assign remaining_next = diff[ISSUE_W] ? '0 : diff[ISSUE_W-1:0];

  always_ff @(posedge clk_sm or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt     <= '0;
      v_reg         <= '0;
      SM1_remaining <= '0;
    end else begin
      epoch_cnt     <= (epoch_cnt == LAST) ? '0 : epoch_cnt + 1'b1;
      SM1_remaining <= remaining_next;
      if (boundary) begin
        v_reg <= SM1_voltage;
      end
    end
  end

endmodule

// File: tb/tb_full_control_system.sv
// Randomised and directed bench for full_control_system against an epoch-level budget model.
module tb_full_control_system;

  localparam int EP = 16;

  logic       clk_sm;
  logic       rst_n;
  logic [7:0] SM1_voltage;
  logic [4:0] SM1_issued_this_cycle;
  logic [4:0] SM1_remaining;

  int checks   = 0;
  int failures = 0;

  // Reference model state: position within the epoch and budget left.
  int m_pos = 0;
  int m_rem = 0;

  full_control_system #(.EPOCH_LEN(EP)) dut (
    .clk_sm                (clk_sm),
    .rst_n                 (rst_n),
    .SM1_voltage           (SM1_voltage),
    .SM1_issued_this_cycle (SM1_issued_this_cycle),
    .SM1_remaining         (SM1_remaining)
  );

  initial begin
    clk_sm = 1'b0;
    forever #5 clk_sm = ~clk_sm;
  end

  function automatic int budget_of(input int volt);
    int lvl;
    lvl = volt / 32;
    return (lvl == 7) ? 31 : 4 * (lvl + 1);
  endfunction

  function automatic void model_edge(input int volt, input int iss);
    int base;
    base  = (m_pos == 0) ? budget_of(volt) : m_rem;
    m_rem = (base > iss) ? base - iss : 0;
    m_pos = (m_pos + 1) % EP;
  endfunction

  // Drive inputs, take one rising edge, advance the model, settle past the edge.
  task automatic cycle(input int volt, input int iss);
    SM1_voltage           = 8'(volt);
    SM1_issued_this_cycle = 5'(iss);
    @(posedge clk_sm);
    model_edge(volt, iss);
    #1;
  endtask

  // Short low pulse between edges; the following edge starts a fresh epoch.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    m_pos = 0;
    m_rem = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SM1_voltage = 8'hFF;
    SM1_issued_this_cycle = 5'd0;
    #2;
    checks++;
    if (SM1_remaining !== 5'd0) begin
      failures++;
      $display("FAIL reset_async got=%0d want=0", SM1_remaining);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_sm);
      #1;
      checks++;
      if (SM1_remaining !== 5'd0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%0d want=0", k, SM1_remaining);
      end
    end
    m_pos = 0;
    m_rem = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_low_voltage();
    pulse_reset();
    for (int k = 0; k < 2 * EP + 1; k++) begin
      cycle(1, 2);
      checks++;
      if (SM1_remaining !== 5'(m_rem) || m_rem != ((k % EP == 0) ? 2 : 0)) begin
        failures++;
        $display("FAIL low_voltage cycle=%0d got=%0d want=%0d", k, SM1_remaining, (k % EP == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_full_voltage();
    pulse_reset();
    for (int k = 0; k < EP + 2; k++) begin
      cycle(8'hFF, 1);
      checks++;
      if (SM1_remaining !== 5'(30 - (k % EP))) begin
        failures++;
        $display("FAIL full_voltage cycle=%0d got=%0d want=%0d", k, SM1_remaining, 30 - (k % EP));
      end
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(8'h60, 20);
      checks++;
      if (SM1_remaining !== 5'd0) begin
        failures++;
        $display("FAIL saturation cycle=%0d got=%0d want=0", k, SM1_remaining);
      end
    end
  endtask

  task automatic test_mid_epoch_voltage();
    int want;
    pulse_reset();
    for (int k = 0; k <= EP; k++) begin
      cycle((k < 5) ? 8'h00 : 8'hC0, (k == 0 || k == EP) ? 1 : 0);
      want = (k == EP) ? 27 : 3;
      checks++;
      if (SM1_remaining !== 5'(want)) begin
        failures++;
        $display("FAIL mid_epoch_voltage cycle=%0d got=%0d want=%0d", k, SM1_remaining, want);
      end
    end
  endtask

  task automatic test_reset_mid_epoch();
    pulse_reset();
    for (int k = 0; k < 6; k++) cycle(8'hA0, 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (SM1_remaining !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_epoch_async got=%0d want=0", SM1_remaining);
    end
    m_pos = 0;
    m_rem = 0;
    rst_n = 1'b1;
    cycle(8'h20, 3);
    checks++;
    if (SM1_remaining !== 5'd5) begin
      failures++;
      $display("FAIL reset_mid_epoch_boundary got=%0d want=5", SM1_remaining);
    end
  endtask

  task automatic test_hold_zero_issue();
    pulse_reset();
    for (int k = 0; k < EP; k++) begin
      cycle(8'hA0, 0);
      checks++;
      if (SM1_remaining !== 5'd24) begin
        failures++;
        $display("FAIL hold_zero_issue cycle=%0d got=%0d want=24", k, SM1_remaining);
      end
    end
  endtask

  task automatic test_random();
    int volt;
    int iss;
    pulse_reset();
    for (int k = 0; k < 300; k++) begin
      volt = $urandom_range(0, 255);
      iss  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 6);
      if ($urandom_range(0, 15) == 0) iss = $urandom_range(0, 31);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      cycle(volt, iss);
      checks++;
      if (SM1_remaining !== 5'(m_rem)) begin
        failures++;
        $display("FAIL random cycle=%0d volt=%0d iss=%0d got=%0d want=%0d", k, volt, iss, SM1_remaining, m_rem);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    SM1_voltage = '0;
    SM1_issued_this_cycle = '0;
    @(negedge clk_sm);
    test_reset();
    test_low_voltage();
    test_full_voltage();
    test_saturation();
    test_mid_epoch_voltage();
    test_reset_mid_epoch();
    test_hold_zero_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
